imem_loader: RTL
================

# imem_loader

Program loader that fills the 128×32 instruction memory from an 8-bit byte stream before the processor runs. It packs four bytes big-endian into each instruction word (first byte becomes bits 31:24, the opcode field) and issues one write per word at consecutive word addresses starting at 0. It holds the CPU (`cpu_hold`) for the whole session. It is the write side of the instruction memory, whose read port decodes words at address `pc`.

## Interface
Parameters:
- `DEPTH`, 128: instruction memory depth in words.
- `ADDR_W`, 7: word address width, equal to clog2(DEPTH).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: begin a load session; sampled only in IDLE.
- `word_count`  in  ADDR_W+1: number of words to load (0..DEPTH); sampled with `start`.
- `byte_valid`  in  1: source presents `byte_data`.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `we`  out  1: instruction memory write enable.
- `waddr`  out  ADDR_W: word write address.
- `wdata`  out  32: packed instruction word.
- `busy`  out  1: session in progress (state ≠ IDLE).
- `cpu_hold`  out  1: stall the processor; equal to `busy`.
- `done`  out  1: one-cycle pulse at session end.
- `err`  out  1: one-cycle pulse with `done` when `word_count` > DEPTH.

## Operation
- States:
  - IDLE → RECV on `start` with 0 < `word_count` ≤ DEPTH.
  - IDLE → DONE on `start` with `word_count` = 0, or with `word_count` > DEPTH (sets `err`).
  - RECV → WRITE after the 4th byte of a word is accepted.
  - WRITE → RECV if more words remain, otherwise WRITE → DONE.
  - DONE → IDLE unconditionally.
- A byte is accepted when `byte_valid` and `byte_ready` are both high at a rising edge. `byte_ready` = (state == RECV). `byte_data` is don't-care while `byte_valid` is low.
- Packing: byte k of a word (k = 0..3) goes to bits [31-8k : 24-8k]. A 2-bit byte counter wraps 3→0 on the 4th accept.
- Word counter starts at 0 and drives `waddr`. It increments after each WRITE cycle. Remaining = `word_count` − written. When `word_count` = DEPTH the last write is at address DEPTH-1; no wrap occurs.
- `start` is ignored outside IDLE. Extra bytes after the last word are not accepted, because `byte_ready` is low.
- The err path performs no writes.
- Memory contents are never cleared by the loader.

## Timing
- Reset (`rst_n` low at an edge): state = IDLE, counters = 0, and all outputs = 0 (`byte_ready`, `we`, `waddr`, `wdata`, `busy`, `cpu_hold`, `done`, `err`).
- Reset mid-session: the partial word is discarded and words already written remain in memory.
- `start` accepted at edge t:
  - `busy`/`cpu_hold` are high from cycle t+1.
  - `byte_ready` is high from t+1 when the next state is RECV.
- 4th byte accepted at edge e: `we` = 1 in cycle e+1, with `waddr`/`wdata` registered and stable that cycle. `byte_ready` = 0 during WRITE.
- Minimum cost is 5 cycles per word. With `byte_valid` held high, N words complete with `done` in cycle 5N+1 after the start cycle. `busy` drops the cycle after DONE.
- `we` is high only in WRITE; `waddr`/`wdata` hold their last values otherwise.
- `done` and `err` last exactly one cycle. `cpu_hold` is still high during the `done` cycle.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_DEPTH` = 128 and `IMEM_ADDR_W` = 7.
  - Instruction field bit positions: opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0.
  - Loader state enum {IDLE, RECV, WRITE, DONE}.
  - Reusing the field positions keeps the decode side and the loader consistent.
- One sub-module `byte_packer` (4-byte shift/assemble register plus byte counter with wrap flag). FSM and word counter stay in `imem_loader`.

## Test plan
- Reset: drive `rst_n`=0 mid-RECV after 2 bytes → all outputs 0 next cycle. A new session then writes the first word correctly, with no stale bytes.
- Single word: `word_count`=1; bytes 0x00,0x22,0x18,0x20 with `byte_valid` held high → `we` pulse with `waddr`=0, `wdata`=0x00221820. `done` follows the next cycle, 6 cycles after start.
- Backpressure/gaps: `word_count`=2 with `byte_valid` toggling 1/0 → words 0x80221820 @0 and 0x00221822 @1. There is no write until each 4th byte is accepted.
- Full depth: `word_count`=128, incrementing-pattern words → 128 writes at addresses 0..127, no wrap. `byte_ready` stays low after the last byte; `done` arrives at cycle 641.
- Zero and overflow: `word_count`=0 → `done` next cycle, `err`=0, no `we`. `word_count`=129 → `done`=`err`=1 for one cycle, no `we`.
- Start while busy: pulse `start` with a different `word_count` during RECV → ignored. The original count completes.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its program loader.
// Field positions are shared so the decode side and the loader agree.
package imem_pkg;

    localparam int IMEM_DEPTH  = 128;
    localparam int IMEM_ADDR_W = 7;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } load_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] w);
        return w[OPCODE_HI:OPCODE_LO];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] w);
        return w[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] w);
        return w[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] w);
        return w[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] shamt_of(input logic [31:0] w);
        return w[SHAMT_HI:SHAMT_LO];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] w);
        return w[FUNCT_HI:FUNCT_LO];
    endfunction

    function automatic logic [15:0] imm_of(input logic [31:0] w);
        return w[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte assembler: first accepted byte lands in bits 31:24.
// wrap marks the accept that completes a word.
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        wrap
);

    logic [23:0] shreg;
    logic [1:0]  count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
        end else if (accept) begin
            shreg <= {shreg[15:0], byte_data};
            count <= count + 2'd1;
        end
    end

    // Only three bytes are stored; the fourth is taken straight from the bus.
    assign word = {shreg, byte_data};
    assign wrap = accept && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into 32-bit words and writes them to
// instruction memory from address 0, holding the CPU meanwhile.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    load_state_t       state;
    load_state_t       next_state;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   next_cnt;
    logic [ADDR_W:0]   total;
    logic              err_flag;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              wrap;
    logic [31:0]       packed_word;
    logic              start_ok;
    logic              start_bad;

    assign accept    = byte_valid && byte_ready;
    assign next_cnt  = word_cnt + 1'b1;
    assign start_bad = (word_count == '0) || (word_count > DEPTH_W);
    assign start_ok  = !start_bad;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == IDLE),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (packed_word),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            total    <= '0;
            err_flag <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                total    <= word_count;
                word_cnt <= '0;
                err_flag <= word_count > DEPTH_W;
            end
            if (wrap) begin
                waddr_q <= word_cnt[ADDR_W-1:0];
                wdata_q <= packed_word;
            end
            if (state == WRITE) begin
                word_cnt <= next_cnt;
            end
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        we         = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = start_ok ? RECV : DONE;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (wrap) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                we         = 1'b1;
                next_state = (next_cnt < total) ? RECV : DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_flag;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign cpu_hold = busy;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

endmodule
